// File: rtl/apb_req_arbiter_if.sv
// APB completer-side bus bundle for apb_req_arbiter.
// master = arbiter driving the bus, slave = the completer.
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter feeding one AMBA 3 APB completer.
// Optional ACCESS timeout (16 wait cycles -> slverr) under `APB_REQ_ARBITER_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  apb_req_arbiter_if.master       apb
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_lane;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_lane;

  logic                  last_q;
  logic                  gnt_q;
  logic                  win;
  logic                  hs;
  logic                  to_hit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  slverr_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign addr_lane[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_lane[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Contention goes to whoever was not granted last; otherwise the sole requester.
  always_comb begin
    if (&req_valid) win = ~last_q;
    else            win = ~req_valid[0];
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !preset && |req_valid)
      req_ready = win ? 2'b10 : 2'b01;
  end

  assign hs = |(req_valid & req_ready);

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  logic [3:0] to_cnt;

  always_ff @(posedge pclk) begin
    if (preset || state != ACCESS) to_cnt <= 4'd0;
    else if (!apb.pready)          to_cnt <= to_cnt + 4'd1;
  end

  // Fires on the 16th consecutive stalled ACCESS cycle.
  assign to_hit = (state == ACCESS) && !apb.pready && (to_cnt == 4'hF);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb.pready || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      if (hs) begin
        last_q  <= win;
        gnt_q   <= win;
        addr_q  <= addr_lane[win];
        write_q <= req_write[win];
        wdata_q <= wdata_lane[win];
      end
      if (state == ACCESS && apb.pready) begin
        rdata_q  <= apb.prdata;
        slverr_q <= apb.pslverr;
      end else if (to_hit) begin
        rdata_q  <= '0;
        slverr_q <= 1'b1;
      end
    end
  end

  assign apb.psel    = (state == SETUP) || (state == ACCESS);
  assign apb.penable = (state == ACCESS);
  assign apb.paddr   = addr_q;
  assign apb.pwrite  = write_q;
  assign apb.pwdata  = wdata_q;

  always_comb begin
    rsp_valid  = 2'b00;
    rsp_slverr = 1'b0;
    rsp_rdata  = '0;
    if (state == DONE) begin
      rsp_valid  = gnt_q ? 2'b10 : 2'b01;
      rsp_slverr = slverr_q;
      rsp_rdata  = write_q ? '0 : rdata_q;
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus random
// transfers against a transaction-level round-robin/latency model.
module tb_apb_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic [1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .apb        (apb)
  );

  always #5 pclk = ~pclk;

  int n_pass  = 0;
  int n_total = 0;
  bit model_last;

  task automatic apply_reset();
    @(negedge pclk);
    preset = 1'b1; req_valid = 2'b00; apb.pready = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    model_last = 1'b1;
  endtask

  // One transfer: model predicts winner, latency and response; bench acts as completer.
  task automatic do_xfer(input string tag, input logic [1:0] vmask, input logic [1:0] wr,
                         input logic [2*AW-1:0] addrs, input logic [2*DW-1:0] wds,
                         input int waits, input logic [DW-1:0] rd, input logic err);
    int          exp_w, exp_lat, lat, acc;
    bit          timeout, got;
    logic [1:0]  exp_oh;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rd;
    logic        exp_err;
    logic [68:0] s_got, s_exp;
    logic [34:0] r_got, r_exp;

    exp_w = (vmask == 2'b11) ? (model_last ? 0 : 1) : (vmask[0] ? 0 : 1);
    exp_oh = (exp_w == 1) ? 2'b10 : 2'b01;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    timeout = (waits >= 16);
`else
    timeout = 1'b0;
`endif
    exp_lat  = timeout ? 18 : 3 + waits;
    exp_addr = addrs[exp_w*AW +: AW];
    exp_wd   = wds[exp_w*DW +: DW];
    exp_rd   = (timeout || wr[exp_w]) ? '0 : rd;
    exp_err  = timeout ? 1'b1 : err;

    @(negedge pclk);
    req_valid = vmask; req_write = wr; req_addr = addrs; req_wdata = wds;
    apb.pready = 1'b0; apb.prdata = rd; apb.pslverr = err;
    #1;
    n_total++;
    if (req_ready !== exp_oh)
      $display("FAIL ready_%s: got %b want %b", tag, req_ready, exp_oh);
    else n_pass++;
    model_last = exp_w[0];

    lat = 0; acc = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge pclk);
      lat++;
      if (apb.psel && apb.penable) begin
        apb.pready = (acc == waits);
        acc++;
      end else apb.pready = 1'b0;
      #1;
      if (lat == 1) begin
        s_got = {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, req_ready};
        s_exp = {1'b1, 1'b0, wr[exp_w], exp_addr, exp_wd, 2'b00};
        n_total++;
        if (s_got !== s_exp)
          $display("FAIL setup_%s: got %h want %h", tag, s_got, s_exp);
        else n_pass++;
      end
      if (rsp_valid !== 2'b00) begin
        got = 1'b1;
        n_total++;
        if (lat != exp_lat)
          $display("FAIL latency_%s: got %0d want %0d", tag, lat, exp_lat);
        else n_pass++;
        r_got = {rsp_valid, rsp_slverr, rsp_rdata};
        r_exp = {exp_oh, exp_err, exp_rd};
        n_total++;
        if (r_got !== r_exp)
          $display("FAIL rsp_%s: got %h want %h", tag, r_got, r_exp);
        else n_pass++;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL norsp_%s: got no rsp_valid want one after %0d cycles", tag, exp_lat);
    end
    apb.pready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    preset = 1'b1; req_valid = 2'b11;
    @(negedge pclk); @(negedge pclk); #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready);
    else n_pass++;
    n_total++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0)
      $display("FAIL reset_apb: got %b%b%b %h %h want all 0", apb.psel, apb.penable,
               apb.pwrite, apb.paddr, apb.pwdata);
    else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_slverr, rsp_rdata} !== '0)
      $display("FAIL reset_rsp: got %b %b %h want 0", rsp_valid, rsp_slverr, rsp_rdata);
    else n_pass++;
    preset = 1'b0; req_valid = 2'b00;
    model_last = 1'b1;
  endtask

  task automatic test_write();
    do_xfer("wr0", 2'b01, 2'b01, {32'h0, 32'h10}, {32'h0, 32'hA5A5_0001}, 0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_read_wait();
    do_xfer("rd1", 2'b10, 2'b00, {32'h20, 32'h0}, '0, 2, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_slverr();
    do_xfer("err0", 2'b01, 2'b00, {32'h0, 32'h44}, '0, 0, 32'h0BAD_F00D, 1'b1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 4; k++)
      do_xfer("rr", 2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 2)), $urandom, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++)
      do_xfer("rand", 2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, int'($urandom_range(0, 4)), $urandom, 1'($urandom));
  endtask

  task automatic test_mid_reset();
    logic [1:0] seen;
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h88};
    apb.pready = 1'b0; #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL midrst_ready: got %b want 01", req_ready);
    else n_pass++;
    @(negedge pclk);
    req_valid = 2'b00;
    @(negedge pclk); #1;
    n_total++;
    if ({apb.psel, apb.penable} !== 2'b11)
      $display("FAIL midrst_access: got %b%b want 11", apb.psel, apb.penable);
    else n_pass++;
    preset = 1'b1;
    @(negedge pclk); #1;
    n_total++;
    if ({apb.psel, rsp_valid} !== 3'b000)
      $display("FAIL midrst_psel: got %b %b want 0 00", apb.psel, rsp_valid);
    else n_pass++;
    preset = 1'b0; model_last = 1'b1;
    seen = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk); #1;
      seen |= rsp_valid;
    end
    n_total++;
    if (seen !== 2'b00) $display("FAIL midrst_norsp: got %b want 00", seen);
    else n_pass++;
    do_xfer("post1", 2'b10, 2'b10, {32'h99, 32'h0}, {32'h5151_7373, 32'h0}, 1, 32'h0, 1'b0);
    do_xfer("post2", 2'b11, 2'b00, {32'h11, 32'h22}, '0, 0, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    do_xfer("tmo", 2'b01, 2'b00, {32'h0, 32'h30}, '0, 1000, 32'hFFFF_FFFF, 1'b0);
    do_xfer("tmo15", 2'b10, 2'b00, {32'h34, 32'h0}, '0, 15, 32'h1357_9BDF, 1'b0);
`else
    logic [1:0] seen;
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h30}; apb.pready = 1'b0;
    @(negedge pclk);
    req_valid = 2'b00;
    seen = 2'b00;
    for (int k = 0; k < 100; k++) begin
      @(negedge pclk); #1;
      seen |= rsp_valid;
    end
    n_total++;
    if ({seen, apb.psel, apb.penable} !== 4'b0011)
      $display("FAIL notimeout: got rsp %b sel/en %b%b want 00 11", seen, apb.psel, apb.penable);
    else n_pass++;
    apply_reset();
`endif
  endtask

  initial begin
    preset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    model_last = 1'b1;
    repeat (2) @(negedge pclk);
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_round_robin();
    test_random();
    test_mid_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
